// File: rtl/laplace_line_buffer.sv
// rtl/laplace_line_buffer.sv - three-row line buffer feeding the Laplace 3x3 filter
//
// Accepts a raster pixel stream and keeps the two previous image lines in two
// ping-pong line memories. From row 2 of each frame onward, every accepted
// pixel produces a vertically aligned column {row r-2, row r-1, row r}. The
// column is held in a one-entry output register behind a valid/ack handshake.
//
// Optional feature macro: LINEBUF_EOL_EN adds o_eol, which flags the column
// taken from the last pixel position of a line.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_pixel        raster-order input pixel (8 bit)
//   i_pixel_valid  i_pixel is valid
//   o_pixel_ack    block accepts i_pixel this cycle (combinational)
//   o_pixel_1      column pixel from row r-2
//   o_pixel_2      column pixel from row r-1
//   o_pixel_3      column pixel from row r (current input)
//   o_pixel_valid  o_pixel_1..3 hold a valid column
//   i_pixel_ack    downstream accepts the output column
//   o_eol          (LINEBUF_EOL_EN only) held column is the last of its line

module laplace_line_buffer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pixel,
  input  logic       i_pixel_valid,
  output logic       o_pixel_ack,
  output logic [7:0] o_pixel_1,
  output logic [7:0] o_pixel_2,
  output logic [7:0] o_pixel_3,
  output logic       o_pixel_valid,
  input  logic       i_pixel_ack
`ifdef LINEBUF_EOL_EN
  ,
  output logic       o_eol
`endif
);

  typedef enum logic {
    FILL,
    STREAM
  } state_t;

  state_t state;

  // Line memories; contents are never cleared, FILL overwrites them first.
  logic [7:0] buf0 [IMG_WIDTH];
  logic [7:0] buf1 [IMG_WIDTH];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             wsel;

  logic       in_xfer;
  logic       out_xfer;
  logic       last_col;
  logic       last_row;
  logic [7:0] older;
  logic [7:0] middle;

  // The output register drains and refills in the same cycle when ack is high.
  assign o_pixel_ack = !o_pixel_valid || i_pixel_ack;
  assign in_xfer     = i_pixel_valid && o_pixel_ack;
  assign out_xfer    = o_pixel_valid && i_pixel_ack;
  assign last_col    = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row    = (row == ROW_W'(IMG_HEIGHT - 1));

  // The memory about to be overwritten still holds row r-2; the other one
  // holds row r-1. Reads are asynchronous, so both see pre-write data.
  always_comb begin
    older  = 8'd0;
    middle = 8'd0;
    if (wsel) begin
      older  = buf1[col];
      middle = buf0[col];
    end else begin
      older  = buf0[col];
      middle = buf1[col];
    end
  end

  always_ff @(posedge i_clk) begin
    if (in_xfer) begin
      if (wsel) begin
        buf1[col] <= i_pixel;
      end else begin
        buf0[col] <= i_pixel;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= FILL;
      col           <= '0;
      row           <= '0;
      wsel          <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_pixel_1     <= 8'd0;
      o_pixel_2     <= 8'd0;
      o_pixel_3     <= 8'd0;
`ifdef LINEBUF_EOL_EN
      o_eol         <= 1'b0;
`endif
    end else begin
      // An acceptance in FILL still consumes a pending column (ack implies
      // the register was empty or draining), so valid clears in that case.
      if (in_xfer && state == STREAM) begin
        o_pixel_1     <= older;
        o_pixel_2     <= middle;
        o_pixel_3     <= i_pixel;
        o_pixel_valid <= 1'b1;
`ifdef LINEBUF_EOL_EN
        o_eol         <= last_col;
`endif
      end else if (out_xfer) begin
        o_pixel_valid <= 1'b0;
      end

      if (in_xfer) begin
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row  <= '0;
            wsel <= 1'b0;
          end else begin
            row  <= row + ROW_W'(1);
            wsel <= !wsel;
          end
        end else begin
          col <= col + COL_W'(1);
        end

        case (state)
          FILL: begin
            if (last_col && row == ROW_W'(1)) begin
              state <= STREAM;
            end
          end
          STREAM: begin
            if (last_col && last_row) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laplace_line_buffer.sv
// tb/tb_laplace_line_buffer.sv - self-checking bench for laplace_line_buffer
module tb_laplace_line_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4x4 directed scenarios. Instance B: 8x5 random handshakes.
  logic [7:0] a_pix = 8'd0, b_pix = 8'd0;
  logic a_vin = 1'b0, b_vin = 1'b0;
  logic a_ack = 1'b0, b_ack = 1'b0;
  logic a_oack, b_oack, a_oval, b_oval;
  logic [7:0] a_p1, a_p2, a_p3, b_p1, b_p2, b_p3;
  logic a_eol, b_eol;

`ifndef LINEBUF_EOL_EN
  assign a_eol = 1'b0;
  assign b_eol = 1'b0;
`endif

  laplace_line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .COL_W(2), .ROW_W(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_pixel(a_pix), .i_pixel_valid(a_vin),
    .o_pixel_ack(a_oack), .o_pixel_1(a_p1), .o_pixel_2(a_p2), .o_pixel_3(a_p3),
    .o_pixel_valid(a_oval), .i_pixel_ack(a_ack)
`ifdef LINEBUF_EOL_EN
    , .o_eol(a_eol)
`endif
  );

  laplace_line_buffer #(.IMG_WIDTH(8), .IMG_HEIGHT(5), .COL_W(3), .ROW_W(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pixel(b_pix), .i_pixel_valid(b_vin),
    .o_pixel_ack(b_oack), .o_pixel_1(b_p1), .o_pixel_2(b_p2), .o_pixel_3(b_p3),
    .o_pixel_valid(b_oval), .i_pixel_ack(b_ack)
`ifdef LINEBUF_EOL_EN
    , .o_eol(b_eol)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: the frame is kept as a 2-D image; a column is simply the pixels
  // two and one rows above the accepted pixel, plus the pixel itself.
  int         mw [2] = '{4, 8};
  int         mh [2] = '{4, 5};
  logic [7:0] img [2][5][8];
  int         mrow [2], mcol [2], mprod [2];
  logic       mval [2], meol [2];
  logic [7:0] m1 [2], m2 [2], m3 [2];
  logic       s_vin, s_ack, s_acc;
  logic [7:0] s_pix;

  initial begin
    mprod[0] = 0;
    mprod[1] = 0;
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mval[k] = 1'b0; meol[k] = 1'b0;
        m1[k] = 8'd0; m2[k] = 8'd0; m3[k] = 8'd0;
        mrow[k] = 0; mcol[k] = 0;
      end else begin
        s_vin = (k == 0) ? a_vin : b_vin;
        s_ack = (k == 0) ? a_ack : b_ack;
        s_pix = (k == 0) ? a_pix : b_pix;
        s_acc = s_vin && (!mval[k] || s_ack);
        if (s_acc) begin
          img[k][mrow[k]][mcol[k]] = s_pix;
          if (mrow[k] >= 2) begin
            m1[k] = img[k][mrow[k]-2][mcol[k]];
            m2[k] = img[k][mrow[k]-1][mcol[k]];
            m3[k] = s_pix;
            meol[k] = (mcol[k] == mw[k] - 1);
            mval[k] = 1'b1;
            mprod[k]++;
          end else if (mval[k] && s_ack) begin
            mval[k] = 1'b0;
          end
          mcol[k]++;
          if (mcol[k] == mw[k]) begin
            mcol[k] = 0;
            mrow[k]++;
            if (mrow[k] == mh[k]) mrow[k] = 0;
          end
        end else if (mval[k] && s_ack) begin
          mval[k] = 1'b0;
        end
      end
    end
  end

  // Compare process: every negedge, both instances against the model.
  int xfer [2] = '{0, 0};
  int eol_xfer_a = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("a_ack", a_oack, !mval[0] || a_ack);
      chk("a_valid", a_oval, mval[0]);
      if (mval[0]) begin
        chk("a_col", {a_p1, a_p2, a_p3}, {m1[0], m2[0], m3[0]});
`ifdef LINEBUF_EOL_EN
        chk("a_eol", a_eol, meol[0]);
`endif
      end
      chk("b_ack", b_oack, !mval[1] || b_ack);
      chk("b_valid", b_oval, mval[1]);
      if (mval[1]) begin
        chk("b_col", {b_p1, b_p2, b_p3}, {m1[1], m2[1], m3[1]});
`ifdef LINEBUF_EOL_EN
        chk("b_eol", b_eol, meol[1]);
`endif
      end
      if (a_oval && a_ack && !rst) begin
        xfer[0]++;
        if (a_eol) eol_xfer_a++;
      end
      if (b_oval && b_ack && !rst) xfer[1]++;
    end
  end

  task automatic drive_a(input logic [7:0] px, input logic v, input logic ak);
    a_pix = px; a_vin = v; a_ack = ak;
    @(posedge clk); #1;
  endtask

  int base, ebase;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", a_oval, 1'b0);
    chk("rst_ack", a_oack, 1'b1);
    chk("rst_col", {a_p1, a_p2, a_p3}, 24'h000000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1 with one backpressure episode after the first column
    base = xfer[0]; ebase = eol_xfer_a;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        drive_a(8'(16*r + c), 1'b1, 1'b1);
        chk("fill_no_valid", a_oval, 1'b0);
      end
    drive_a(8'h20, 1'b1, 1'b1);
    chk("first_col", {a_p1, a_p2, a_p3}, 24'h001020);
    for (int i = 0; i < 3; i++) begin
      drive_a(8'h21, 1'b1, 1'b0);
      chk("bp_ack_low", a_oack, 1'b0);
      chk("bp_hold", {a_p1, a_p2, a_p3}, 24'h001020);
    end
    drive_a(8'h21, 1'b1, 1'b1);
    chk("bp_release", {a_p1, a_p2, a_p3}, 24'h011121);
    drive_a(8'h22, 1'b1, 1'b1);
    drive_a(8'h23, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) drive_a(8'(8'h30 + c), 1'b1, 1'b1);
    chk("last_col", {a_p1, a_p2, a_p3}, 24'h132333);
    drive_a(8'h00, 1'b0, 1'b1);
    drive_a(8'h00, 1'b0, 1'b1);
    chk("frame1_count", xfer[0] - base, 8);
`ifdef LINEBUF_EOL_EN
    chk("eol_count", eol_xfer_a - ebase, 2);
`endif

    // Frame 2, values +0x80
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        drive_a(8'(8'h80 + 16*r + c), 1'b1, 1'b1);
        if (r < 2) chk("f2_fill", a_oval, 1'b0);
        if (r == 2 && c == 0) chk("f2_first", {a_p1, a_p2, a_p3}, 24'h8090A0);
      end
    drive_a(8'h00, 1'b0, 1'b1);

    // Frame 3 interrupted by reset at row 2 col 1
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 2 : 4); c++)
        drive_a(8'(16*r + c), 1'b1, 1'b1);
    chk("pre_rst_valid", a_oval, 1'b1);
    a_vin = 1'b0; a_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_drop", a_oval, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        drive_a(8'(8'h40 + 16*r + c), 1'b1, 1'b1);
        if (r < 2) chk("post_rst_fill", a_oval, 1'b0);
        if (r == 2 && c == 0) chk("post_rst_first", {a_p1, a_p2, a_p3}, 24'h405060);
      end
    drive_a(8'h00, 1'b0, 1'b1);

    // Instance B: random valid gaps and random ack
    for (int i = 0; i < 1000; i++) begin
      b_pix = 8'($urandom);
      b_vin = 1'($urandom_range(0, 1));
      b_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    b_vin = 1'b0; b_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_no_loss", xfer[1], mprod[1]);
    chk("b_drained", b_oval, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/laplace_line_buffer.md
# laplace_line_buffer

Three-row line buffer feeding the Laplace 3x3 filter stage (filter_x). It accepts a raster pixel stream, one 8-bit pixel per transfer, and stores the two previous image lines. For every pixel of row 2 onward it emits a vertically aligned column of three pixels (oldest row first) through a valid/ack handshake that matches the filter's input port. It also restarts the fill sequence at each frame boundary.

## Interface
- IMG_WIDTH, 512: pixels per line; must be >= 2.
- IMG_HEIGHT, 512: lines per frame; must be >= 3.
- COL_W, 9: column counter width; must satisfy 2^COL_W >= IMG_WIDTH.
- ROW_W, 9: row counter width; must satisfy 2^ROW_W >= IMG_HEIGHT.

Ports:
- i_clk  input  1: single clock; all logic on the rising edge.
- i_rst  input  1: asynchronous, active-high reset.
- i_pixel  input  8: raster-order input pixel.
- i_pixel_valid  input  1: i_pixel is valid.
- o_pixel_ack  output  1: block can accept i_pixel this cycle.
- o_pixel_1  output  8: column pixel from row r-2.
- o_pixel_2  output  8: column pixel from row r-1.
- o_pixel_3  output  8: column pixel from row r (the current input).
- o_pixel_valid  output  1: o_pixel_1..3 are valid.
- i_pixel_ack  input  1: downstream accepts the output column.
- o_eol  output  1: present only with LINEBUF_EOL_EN (see Configuration).

## Operation
- Input transfer: i_pixel_valid & o_pixel_ack. Output transfer: o_pixel_valid & i_pixel_ack.
- o_pixel_ack = !o_pixel_valid | i_pixel_ack. It is combinational and forms a one-entry output register with pass-through on drain.
- Storage: two line memories, buf0 and buf1, each IMG_WIDTH x 8. Read is asynchronous. A write at the same address in the same cycle returns the old data (read-before-write).
- wsel selects the write memory. On an accepted pixel at column col:
  - older = buf[wsel][col], middle = buf[!wsel][col].
  - Write i_pixel into buf[wsel][col].
- Counters:
  - col increments on each accepted pixel and wraps from IMG_WIDTH-1 to 0.
  - On that wrap, wsel toggles and row increments.
  - When row wraps from IMG_HEIGHT-1 to 0, wsel returns to 0.
- State machine:
  - FILL (rows 0-1): pixels are written to memory; no output is produced.
  - FILL -> STREAM on acceptance of the last pixel of row 1.
  - STREAM (rows 2 .. IMG_HEIGHT-1): every accepted pixel loads {o_pixel_1, o_pixel_2, o_pixel_3} <= {older, middle, i_pixel} and sets o_pixel_valid.
  - STREAM -> FILL on acceptance of the last pixel of row IMG_HEIGHT-1.
- Output columns per frame: IMG_WIDTH * (IMG_HEIGHT-2).
- o_pixel_valid:
  - Set on an accepted pixel in STREAM.
  - Cleared on an output transfer with no new accepted pixel in that cycle.
  - If an output transfer and a new acceptance occur in the same cycle, it stays 1 with the new data.
- Outputs hold stable while o_pixel_valid=1 and i_pixel_ack=0.
- i_pixel_valid is ignored while o_pixel_ack=0; counters do not advance.

## Timing
- Reset values:
  - o_pixel_valid=0 and o_pixel_1/2/3=0.
  - o_pixel_ack=1 (follows from o_pixel_valid=0).
  - col=0, row=0, wsel=0, state FILL, o_eol=0.
  - Memory contents are not cleared; FILL overwrites them before use.
- Latency: the column appears at the outputs 1 cycle after the accepting edge.
- Throughput: 1 pixel/cycle when i_pixel_ack is held high.
- Reset mid-frame:
  - Any pending output is dropped.
  - The next accepted pixel is treated as row 0, col 0.

## Configuration
- LINEBUF_EOL_EN defined: adds output o_eol, registered alongside o_pixel_1..3.
  - o_eol=1 exactly when the held column is col IMG_WIDTH-1.
  - o_eol is held with the data and is meaningful only while o_pixel_valid=1.
- LINEBUF_EOL_EN undefined: o_eol and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and input pixel = 16*row + col, unless stated otherwise.
- Streaming, i_pixel_ack=1: rows 0-1 give no o_pixel_valid. Row 2 col 0 gives {0x00,0x10,0x20} one cycle after acceptance. Row 3 col 3 gives {0x13,0x23,0x33}. Exactly 8 output columns in total.
- Backpressure: hold i_pixel_ack=0 after the first output. o_pixel_ack drops to 0 and outputs stay {0x00,0x10,0x20}. Releasing ack for one cycle accepts the next pixel, and the output becomes {0x01,0x11,0x21}.
- Frame wrap: a second frame with values +0x80 produces no output for its first 8 pixels. Its first column is {0x80,0x90,0xA0}.
- Reset mid-frame: assert i_rst during row 2 col 1 while o_pixel_valid=1. o_pixel_valid goes 0 immediately. A new frame then produces its first output only at row 2.
- Random valid gaps and random ack (1000 cycles, IMG_WIDTH=8, IMG_HEIGHT=5): outputs match the scoreboard column sequence, with no loss or duplication.
- LINEBUF_EOL_EN: o_eol=1 only on the columns with p3=0x23 and p3=0x33.
